// File: rtl/cyclic_prefix_removal.sv
// Strips the cyclic prefix from each OFDM symbol and forwards FFT_LEN-sample windows tagged with a symbol index.
// Optional build macro CP_SKEW_EN advances the window CP_SKEW samples into the prefix and drops a matching tail.
module cyclic_prefix_removal #(
    parameter int unsigned FFT_LEN = 64,
    parameter int unsigned CP_LEN  = 16,
    parameter int unsigned CP_SKEW = 4
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        s_valid,
    output logic        s_ready,
    input  logic [31:0] s_data,
    input  logic        s_last,
    input  logic [15:0] num_symbols,
    output logic        m_valid,
    input  logic        m_ready,
    output logic [31:0] m_data,
    output logic [15:0] m_user,
    output logic        m_last,
    output logic        done
);

    localparam int unsigned CNT_W = $clog2(CP_LEN + FFT_LEN);
`ifdef CP_SKEW_EN
    localparam int unsigned SKEW    = CP_SKEW;
    localparam int unsigned SKEW_M1 = (SKEW == 0) ? 0 : SKEW - 1;
`else
    localparam int unsigned SKEW    = CP_SKEW * 0;
`endif
    localparam int unsigned DISC    = CP_LEN - SKEW;
    localparam int unsigned DISC_M1 = (DISC == 0) ? 0 : DISC - 1;

`ifdef CP_SKEW_EN
    typedef enum logic [1:0] {IDLE, CP, KEEP, TAIL} state_t;
`else
    typedef enum logic [1:0] {IDLE, CP, KEEP} state_t;
`endif

    // A zero-length discard window starts each symbol directly in KEEP.
    localparam state_t START = (DISC == 0) ? KEEP : CP;

    state_t             state, state_nxt;
    logic [CNT_W-1:0]   samp_cnt, samp_nxt;
    logic [15:0]        sym_cnt, sym_nxt;
    logic [15:0]        num_lat, num_nxt;
    logic               accept;
    logic               keep_beat, keep_last, keep_final, end_sym;
    logic               m_final;

    // Next-state, counters and input handshake.
    always_comb begin
        state_nxt  = state;
        samp_nxt   = samp_cnt;
        sym_nxt    = sym_cnt;
        num_nxt    = num_lat;
        keep_beat  = 1'b0;
        keep_last  = 1'b0;
        keep_final = 1'b0;
        end_sym    = 1'b0;
        s_ready    = (state == KEEP) ? (!m_valid || m_ready) : 1'b1;
        accept     = s_valid && s_ready;

        if (accept && s_last) begin
            // Start of packet or resync: the s_last beat itself is never forwarded.
            samp_nxt = '0;
            sym_nxt  = '0;
            if (num_symbols != 16'd0) begin
                state_nxt = START;
                num_nxt   = num_symbols;
            end else begin
                state_nxt = IDLE;
            end
        end else if (accept) begin
            case (state)
                CP: begin
                    if (samp_cnt == CNT_W'(DISC_M1)) begin
                        state_nxt = KEEP;
                        samp_nxt  = '0;
                    end else begin
                        samp_nxt = samp_cnt + CNT_W'(1);
                    end
                end
                KEEP: begin
                    keep_beat = 1'b1;
                    if (samp_cnt == CNT_W'(FFT_LEN - 1)) begin
                        keep_last  = 1'b1;
                        keep_final = (sym_cnt == num_lat - 16'd1);
                        samp_nxt   = '0;
`ifdef CP_SKEW_EN
                        if (SKEW != 0) state_nxt = TAIL;
                        else           end_sym   = 1'b1;
`else
                        end_sym = 1'b1;
`endif
                    end else begin
                        samp_nxt = samp_cnt + CNT_W'(1);
                    end
                end
`ifdef CP_SKEW_EN
                TAIL: begin
                    if (samp_cnt == CNT_W'(SKEW_M1)) begin
                        samp_nxt = '0;
                        end_sym  = 1'b1;
                    end else begin
                        samp_nxt = samp_cnt + CNT_W'(1);
                    end
                end
`endif
                default: ;
            endcase

            if (end_sym) begin
                if (sym_cnt == num_lat - 16'd1) begin
                    state_nxt = IDLE;
                    sym_nxt   = '0;
                end else begin
                    state_nxt = START;
                    sym_nxt   = sym_cnt + 16'd1;
                end
            end
        end
    end

    // State and counter registers.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state    <= IDLE;
            samp_cnt <= '0;
            sym_cnt  <= '0;
            num_lat  <= '0;
        end else begin
            state    <= state_nxt;
            samp_cnt <= samp_nxt;
            sym_cnt  <= sym_nxt;
            num_lat  <= num_nxt;
        end
    end

    // Single-stage output register; m_final marks the last window of the packet for done.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            m_valid <= 1'b0;
            m_data  <= '0;
            m_user  <= '0;
            m_last  <= 1'b0;
            m_final <= 1'b0;
            done    <= 1'b0;
        end else begin
            done <= m_valid && m_ready && m_last && m_final;
            if (keep_beat) begin
                m_valid <= 1'b1;
                m_data  <= s_data;
                m_user  <= sym_cnt;
                m_last  <= keep_last;
                m_final <= keep_final;
            end else if (m_ready) begin
                m_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_cyclic_prefix_removal.sv
// Self-checking bench for cyclic_prefix_removal: positional reference model, random data, random backpressure.
module tb_cyclic_prefix_removal;

    localparam int FFT = 64;
    localparam int CPL = 16;
    localparam int PERIOD = FFT + CPL;
`ifdef CP_SKEW_EN
    localparam int DISC = CPL - 4;
`else
    localparam int DISC = CPL;
`endif

    typedef struct packed {
        logic [31:0] data;
        logic [15:0] user;
        logic        last;
    } beat_t;

    logic        clk;
    logic        resetn;
    logic        s_valid;
    logic        s_ready;
    logic [31:0] s_data;
    logic        s_last;
    logic [15:0] num_symbols;
    logic        m_valid;
    logic        m_ready;
    logic [31:0] m_data;
    logic [15:0] m_user;
    logic        m_last;
    logic        done;

    cyclic_prefix_removal #(.FFT_LEN(64), .CP_LEN(16), .CP_SKEW(4)) dut (
        .clk(clk), .resetn(resetn),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_last(s_last),
        .num_symbols(num_symbols),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_user(m_user),
        .m_last(m_last), .done(done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int    checks = 0;
    int    errors = 0;
    beat_t exp_q[$];
    beat_t obs_q[$];
    int    exp_done[$];
    int    obs_done[$];
    int    stab_err = 0;
    int    sready_err = 0;
    int    sready_low = 0;
    bit    hold = 1'b0;
    beat_t snap;
    bit    rnd_ready = 1'b0;

    bit    md_act = 1'b0;
    int    md_pos = 0;
    int    md_nsym = 0;

    // Reference: position since the last s_last decides which beats form each window.
    function automatic void model_beat(input logic [31:0] d, input logic last, input logic [15:0] num);
        int sym;
        int off;
        beat_t b;
        if (last) begin
            md_act  = (num != 16'd0);
            md_pos  = 0;
            md_nsym = int'(num);
            return;
        end
        if (!md_act) return;
        sym = md_pos / PERIOD;
        off = md_pos % PERIOD;
        if (off >= DISC && off < DISC + FFT) begin
            b.data = d;
            b.user = 16'(sym);
            b.last = (off == DISC + FFT - 1);
            exp_q.push_back(b);
            if (b.last && sym == md_nsym - 1) exp_done.push_back(exp_q.size());
        end
        md_pos++;
        if (md_pos == md_nsym * PERIOD) md_act = 1'b0;
    endfunction

    // Observation: handshakes and flags seen half a cycle ahead of the edge that commits them.
    always @(negedge clk) begin
        if (!resetn) begin
            hold = 1'b0;
        end else begin
            if (hold && (!m_valid || {m_data, m_user, m_last} !== snap)) stab_err++;
            hold = m_valid && !m_ready;
            snap = {m_data, m_user, m_last};
            if (!s_ready) sready_low++;
            if (!s_ready && !(m_valid && !m_ready)) sready_err++;
            if (done) obs_done.push_back(obs_q.size());
            if (m_valid && m_ready) obs_q.push_back(beat_t'({m_data, m_user, m_last}));
        end
    end

    always @(posedge clk) begin
        #1;
        if (rnd_ready) m_ready = ($urandom_range(0, 1) == 1);
    end

    task automatic clear_all();
        exp_q.delete(); obs_q.delete(); exp_done.delete(); obs_done.delete();
        stab_err = 0; sready_err = 0; sready_low = 0;
    endtask

    task automatic drive_beat(input logic [31:0] d, input logic last, input logic [15:0] num, input bit gaps);
        bit got = 1'b0;
        if (gaps) while ($urandom_range(0, 3) == 0) begin s_valid = 1'b0; @(posedge clk); #1; end
        s_valid = 1'b1; s_data = d; s_last = last; num_symbols = num;
        for (int k = 0; k < 500 && !got; k++) begin
            @(negedge clk);
            if (s_ready) begin got = 1'b1; model_beat(d, last, num); end
            @(posedge clk); #1;
        end
        s_valid = 1'b0; s_last = 1'b0;
        if (!got) begin
            checks++; errors++;
            $display("FAIL drive_timeout: s_ready stayed 0 for 500 cycles, required 1");
        end
    endtask

    task automatic drain();
        int k;
        for (k = 0; k < 3000; k++) begin
            if (obs_q.size() >= exp_q.size() && k >= 4) break;
            @(posedge clk); #1;
        end
        if (k == 3000) begin
            checks++; errors++;
            $display("FAIL drain_timeout: got %0d beats, required %0d", obs_q.size(), exp_q.size());
        end
        repeat (4) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL reset_m_valid: got %b required 0", m_valid); end
        checks++; if (m_last !== 1'b0) begin errors++; $display("FAIL reset_m_last: got %b required 0", m_last); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b required 0", done); end
        checks++; if (m_data !== 32'd0 || m_user !== 16'd0) begin
            errors++; $display("FAIL reset_data: got %h/%h required 0/0", m_data, m_user);
        end
        checks++; if (s_ready !== 1'b1) begin errors++; $display("FAIL reset_s_ready: got %b required 1", s_ready); end
    endtask

    task automatic test_basic();
        int nlast = 0;
        clear_all();
        rnd_ready = 1'b0; m_ready = 1'b1;
        drive_beat(32'hdead, 1'b1, 16'd2, 1'b0);
        for (int i = 0; i < 160; i++) drive_beat(32'(i), 1'b0, 16'($urandom), 1'b0);
        drain();
        checks++; if (obs_q.size() !== exp_q.size()) begin
            errors++; $display("FAIL basic_count: got %0d required %0d", obs_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            checks++;
            if (obs_q[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL basic_beat%0d: got d=%0d u=%0d l=%b required d=%0d u=%0d l=%b", i,
                         obs_q[i].data, obs_q[i].user, obs_q[i].last, exp_q[i].data, exp_q[i].user, exp_q[i].last);
            end
        end
        foreach (obs_q[i]) if (obs_q[i].last) nlast++;
        checks++; if (nlast !== 2) begin errors++; $display("FAIL basic_last_count: got %0d required 2", nlast); end
        checks++; if (obs_q.size() == 0 || obs_q[obs_q.size()-1].data !== 32'(PERIOD + DISC + FFT - 1)) begin
            errors++; $display("FAIL basic_final_value: got %0d beats, required last value %0d", obs_q.size(), PERIOD + DISC + FFT - 1);
        end
        checks++; if (obs_done.size() !== 1 || obs_done[0] !== 2 * FFT) begin
            errors++; $display("FAIL basic_done: got %0d pulses, required 1 after beat %0d", obs_done.size(), 2 * FFT);
        end
    endtask

    task automatic test_backpressure();
        clear_all();
        rnd_ready = 1'b1;
        drive_beat(32'hbeef, 1'b1, 16'd2, 1'b0);
        for (int i = 0; i < 160; i++) drive_beat(32'(i), 1'b0, 16'($urandom), 1'b0);
        drain();
        rnd_ready = 1'b0; m_ready = 1'b1;
        checks++; if (obs_q.size() !== exp_q.size()) begin
            errors++; $display("FAIL bp_count: got %0d required %0d", obs_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            checks++;
            if (obs_q[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL bp_beat%0d: got d=%0d u=%0d l=%b required d=%0d u=%0d l=%b", i,
                         obs_q[i].data, obs_q[i].user, obs_q[i].last, exp_q[i].data, exp_q[i].user, exp_q[i].last);
            end
        end
        checks++; if (stab_err !== 0) begin errors++; $display("FAIL bp_stable: got %0d unstable stalls, required 0", stab_err); end
        checks++; if (sready_err !== 0) begin errors++; $display("FAIL bp_s_ready: got %0d bad s_ready lows, required 0", sready_err); end
        checks++; if (obs_done.size() !== exp_done.size() || (exp_done.size() > 0 && obs_done[0] !== exp_done[0])) begin
            errors++; $display("FAIL bp_done: got %0d pulses, required %0d", obs_done.size(), exp_done.size());
        end
    endtask

    task automatic test_resync();
        int nlast = 0;
        clear_all();
        m_ready = 1'b1;
        drive_beat(32'h1, 1'b1, 16'd3, 1'b0);
        for (int i = 0; i < 40; i++) drive_beat(32'(i), 1'b0, 16'd0, 1'b0);
        drive_beat(32'h2, 1'b1, 16'd1, 1'b0);
        for (int i = 0; i < 80; i++) drive_beat(32'(1000 + i), 1'b0, 16'd0, 1'b0);
        drain();
        checks++; if (obs_q.size() !== exp_q.size()) begin
            errors++; $display("FAIL resync_count: got %0d required %0d", obs_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            checks++;
            if (obs_q[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL resync_beat%0d: got d=%0d u=%0d l=%b required d=%0d u=%0d l=%b", i,
                         obs_q[i].data, obs_q[i].user, obs_q[i].last, exp_q[i].data, exp_q[i].user, exp_q[i].last);
            end
        end
        foreach (obs_q[i]) if (obs_q[i].last) nlast++;
        checks++; if (nlast !== 1) begin errors++; $display("FAIL resync_last_count: got %0d required 1", nlast); end
        checks++; if (obs_done.size() !== 1) begin errors++; $display("FAIL resync_done: got %0d pulses, required 1", obs_done.size()); end
    endtask

    task automatic test_zero_symbols();
        clear_all();
        m_ready = 1'b1;
        drive_beat(32'h3, 1'b1, 16'd0, 1'b0);
        for (int i = 0; i < 200; i++) drive_beat($urandom, 1'b0, 16'($urandom), 1'b0);
        drain();
        checks++; if (obs_q.size() !== 0) begin errors++; $display("FAIL zero_output: got %0d beats, required 0", obs_q.size()); end
        checks++; if (obs_done.size() !== 0) begin errors++; $display("FAIL zero_done: got %0d pulses, required 0", obs_done.size()); end
        checks++; if (sready_low !== 0) begin errors++; $display("FAIL zero_s_ready: got %0d low cycles, required 0", sready_low); end
    endtask

    task automatic test_random();
        clear_all();
        rnd_ready = 1'b1;
        for (int p = 0; p < 3; p++) begin
            int n = $urandom_range(1, 3);
            int len = n * PERIOD + $urandom_range(0, 10);
            if (p == 1) len = $urandom_range(30, 150);
            drive_beat($urandom, 1'b1, 16'(n), 1'b1);
            for (int i = 0; i < len; i++) drive_beat($urandom, 1'b0, 16'($urandom), 1'b1);
        end
        drain();
        rnd_ready = 1'b0; m_ready = 1'b1;
        checks++; if (obs_q.size() !== exp_q.size()) begin
            errors++; $display("FAIL rand_count: got %0d required %0d", obs_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            checks++;
            if (obs_q[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL rand_beat%0d: got d=%h u=%0d l=%b required d=%h u=%0d l=%b", i,
                         obs_q[i].data, obs_q[i].user, obs_q[i].last, exp_q[i].data, exp_q[i].user, exp_q[i].last);
            end
        end
        checks++; if (obs_done.size() !== exp_done.size()) begin
            errors++; $display("FAIL rand_done: got %0d pulses, required %0d", obs_done.size(), exp_done.size());
        end
        for (int i = 0; i < exp_done.size() && i < obs_done.size(); i++) begin
            checks++;
            if (obs_done[i] !== exp_done[i]) begin
                errors++; $display("FAIL rand_done_pos%0d: got after beat %0d, required %0d", i, obs_done[i], exp_done[i]);
            end
        end
        checks++; if (stab_err !== 0 || sready_err !== 0) begin
            errors++; $display("FAIL rand_handshake: got %0d/%0d violations, required 0/0", stab_err, sready_err);
        end
    endtask

    task automatic test_async_reset();
        clear_all();
        rnd_ready = 1'b0; m_ready = 1'b0;
        drive_beat(32'h4, 1'b1, 16'd2, 1'b0);
        for (int i = 0; i <= DISC; i++) drive_beat(32'(i), 1'b0, 16'd0, 1'b0);
        checks++; if (m_valid !== 1'b1) begin errors++; $display("FAIL areset_pre_valid: got %b required 1", m_valid); end
        #2 resetn = 1'b0;
        #1;
        checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL areset_m_valid: got %b required 0", m_valid); end
        checks++; if (m_last !== 1'b0 || done !== 1'b0) begin
            errors++; $display("FAIL areset_flags: got last=%b done=%b required 0/0", m_last, done);
        end
        md_act = 1'b0;
        @(posedge clk); #1;
        resetn = 1'b1; m_ready = 1'b1;
        clear_all();
        for (int i = 0; i < 30; i++) drive_beat($urandom, 1'b0, 16'd1, 1'b0);
        drain();
        checks++; if (obs_q.size() !== 0) begin errors++; $display("FAIL areset_no_output: got %0d beats, required 0", obs_q.size()); end
        drive_beat(32'h5, 1'b1, 16'd1, 1'b0);
        for (int i = 0; i < 80; i++) drive_beat(32'(500 + i), 1'b0, 16'd0, 1'b0);
        drain();
        checks++; if (obs_q.size() !== exp_q.size() || obs_q.size() !== FFT) begin
            errors++; $display("FAIL areset_count: got %0d required %0d", obs_q.size(), FFT);
        end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            checks++;
            if (obs_q[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL areset_beat%0d: got d=%0d u=%0d l=%b required d=%0d u=%0d l=%b", i,
                         obs_q[i].data, obs_q[i].user, obs_q[i].last, exp_q[i].data, exp_q[i].user, exp_q[i].last);
            end
        end
        checks++; if (obs_done.size() !== 1) begin errors++; $display("FAIL areset_done: got %0d pulses, required 1", obs_done.size()); end
    endtask

    initial begin
        resetn = 1'b0; s_valid = 1'b0; s_data = '0; s_last = 1'b0; num_symbols = '0; m_ready = 1'b1;
        #3;
        test_reset();
        repeat (2) @(posedge clk);
        #1 resetn = 1'b1;
        test_basic();
        test_backpressure();
        test_resync();
        test_zero_symbols();
        test_random();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
